// File: rtl/plab5_mcore_refill_xbar.sv
// Domain-aware N-port refill crossbar: per-input FIFOs drained by per-output round-robin arbiters.
// Optional per-input domain-stall counters are enabled with PLAB5_MCORE_REFILL_XBAR_STATS_EN.
module plab5_mcore_refill_xbar #(
   parameter int p_num_ports   = 4,
   parameter int p_msg_nbits   = 77,
   parameter int p_sd_nbits    = 1,
   parameter int p_queue_depth = 4,
   parameter int c_dest_nbits  = $clog2(p_num_ports)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [p_num_ports*p_msg_nbits-1:0]    in_msg,
   input  logic [p_num_ports*c_dest_nbits-1:0]   in_dest,
   input  logic [p_num_ports*p_sd_nbits-1:0]     in_sd,
   input  logic [p_num_ports-1:0]                in_val,
   output logic [p_num_ports-1:0]                in_rdy,
   output logic [p_num_ports*p_msg_nbits-1:0]    out_msg,
   output logic [p_num_ports*c_dest_nbits-1:0]   out_src,
   output logic [p_num_ports-1:0]                out_val,
   input  logic [p_num_ports-1:0]                out_rdy,
   input  logic [p_sd_nbits-1:0]                 cur_sd,
   output logic [p_num_ports*16-1:0]             stall_cnt
);
   localparam int c_ptr_nbits = $clog2(p_queue_depth);
   localparam int c_cnt_nbits = c_ptr_nbits + 1;
   localparam int c_ent_nbits = p_msg_nbits + c_dest_nbits + p_sd_nbits;

   logic [c_ent_nbits-1:0]  buf_q    [p_num_ports][p_queue_depth];
   logic [c_ent_nbits-1:0]  buf_d    [p_num_ports][p_queue_depth];
   logic [c_ptr_nbits-1:0]  rd_ptr_q [p_num_ports];
   logic [c_ptr_nbits-1:0]  rd_ptr_d [p_num_ports];
   logic [c_ptr_nbits-1:0]  wr_ptr_q [p_num_ports];
   logic [c_ptr_nbits-1:0]  wr_ptr_d [p_num_ports];
   logic [c_cnt_nbits-1:0]  count_q  [p_num_ports];
   logic [c_cnt_nbits-1:0]  count_d  [p_num_ports];
   logic [c_dest_nbits-1:0] rr_ptr_q [p_num_ports];
   logic [c_dest_nbits-1:0] rr_ptr_d [p_num_ports];

   logic [c_ent_nbits-1:0]  head_ent  [p_num_ports];
   logic [p_msg_nbits-1:0]  head_msg  [p_num_ports];
   logic [c_dest_nbits-1:0] head_dest [p_num_ports];
   logic [p_sd_nbits-1:0]   head_sd   [p_num_ports];
   logic [p_num_ports-1:0]  elig;
   logic [p_num_ports-1:0]  enq;
   logic [p_num_ports-1:0]  deq;

   // Ready looks only at our own occupancy, so other-domain traffic can never block injection.
   always_comb begin
      for (int i = 0; i < p_num_ports; i++) begin
         head_ent[i]  = buf_q[i][rd_ptr_q[i]];
         head_msg[i]  = head_ent[i][p_msg_nbits-1:0];
         head_dest[i] = head_ent[i][p_msg_nbits +: c_dest_nbits];
         head_sd[i]   = head_ent[i][c_ent_nbits-1 -: p_sd_nbits];
         elig[i]      = (count_q[i] != '0) && (head_sd[i] == cur_sd);
         in_rdy[i]    = !reset && (count_q[i] < c_cnt_nbits'(p_queue_depth));
      end
   end

   always_comb begin : arb
      logic found;
      int   gnt;
      int   idx;
      out_val  = '0;
      out_msg  = '0;
      out_src  = '0;
      deq      = '0;
      rr_ptr_d = rr_ptr_q;
      found    = 1'b0;
      gnt      = 0;
      idx      = 0;
      for (int i = 0; i < p_num_ports; i++) begin
         if (elig[i] && (int'(head_dest[i]) >= p_num_ports)) deq[i] = 1'b1;
      end
      for (int j = 0; j < p_num_ports; j++) begin
         found = 1'b0;
         gnt   = 0;
         for (int k = 0; k < p_num_ports; k++) begin
            idx = int'(rr_ptr_q[j]) + k;
            if (idx >= p_num_ports) idx = idx - p_num_ports;
            if (!found && elig[idx] && (int'(head_dest[idx]) == j)) begin
               found = 1'b1;
               gnt   = idx;
            end
         end
         out_val[j]                           = found;
         out_msg[j*p_msg_nbits +: p_msg_nbits] = head_msg[gnt];
         out_src[j*c_dest_nbits +: c_dest_nbits] = c_dest_nbits'(gnt);
         if (found && out_rdy[j]) begin
            deq[gnt]    = 1'b1;
            rr_ptr_d[j] = (gnt == p_num_ports - 1) ? '0 : c_dest_nbits'(gnt + 1);
         end
      end
   end

   always_comb begin
      buf_d = buf_q;
      for (int i = 0; i < p_num_ports; i++) begin
         enq[i]      = in_val[i] && in_rdy[i];
         rd_ptr_d[i] = rd_ptr_q[i] + c_ptr_nbits'(deq[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + c_ptr_nbits'(enq[i]);
         count_d[i]  = count_q[i] + c_cnt_nbits'(enq[i]) - c_cnt_nbits'(deq[i]);
         if (enq[i]) begin
            buf_d[i][wr_ptr_q[i]] = {in_sd[i*p_sd_nbits +: p_sd_nbits],
                                     in_dest[i*c_dest_nbits +: c_dest_nbits],
                                     in_msg[i*p_msg_nbits +: p_msg_nbits]};
         end
      end
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < p_num_ports; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i]  <= '0;
            rr_ptr_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef PLAB5_MCORE_REFILL_XBAR_STATS_EN
   logic [15:0] stall_q [p_num_ports];
   logic [15:0] stall_d [p_num_ports];

   // A stall is a non-empty FIFO whose head belongs to a domain that is not scheduled.
   always_comb begin
      stall_cnt = '0;
      for (int i = 0; i < p_num_ports; i++) begin
         stall_d[i] = stall_q[i];
         if ((count_q[i] != '0) && (head_sd[i] != cur_sd) && (stall_q[i] != 16'hFFFF))
            stall_d[i] = stall_q[i] + 16'd1;
         stall_cnt[i*16 +: 16] = stall_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < p_num_ports; i++) stall_q[i] <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_plab5_mcore_refill_xbar.sv
// Bench for plab5_mcore_refill_xbar: directed sequences, a vector table and random traffic,
// all shadowed by a queue-based reference model of the crossbar.
module tb_plab5_mcore_refill_xbar;
   localparam int N  = 4;
   localparam int M  = 77;
   localparam int S  = 1;
   localparam int D  = 4;
   localparam int NS = 2;
   localparam int E  = M + NS + S;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*M-1:0]  in_msg;
   logic [N*NS-1:0] in_dest;
   logic [N*S-1:0]  in_sd;
   logic [N-1:0]    in_val;
   logic [N-1:0]    in_rdy;
   logic [N*M-1:0]  out_msg;
   logic [N*NS-1:0] out_src;
   logic [N-1:0]    out_val;
   logic [N-1:0]    out_rdy;
   logic [S-1:0]    cur_sd;
   logic [N*16-1:0] stall_cnt;

   plab5_mcore_refill_xbar dut (
      .clk(clk), .reset(reset), .in_msg(in_msg), .in_dest(in_dest), .in_sd(in_sd),
      .in_val(in_val), .in_rdy(in_rdy), .out_msg(out_msg), .out_src(out_src),
      .out_val(out_val), .out_rdy(out_rdy), .cur_sd(cur_sd), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one queue of {sd,dest,msg} per input, a rotating start point per output.
   logic [E-1:0] exp_q [N][$];
   int           rr [N];
   int           stall [N];
   int           deliv_q [$];
   int           n_cmp = 0;
   int           n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      in_msg  = '0;
      in_dest = '0;
      in_sd   = '0;
      in_val  = '0;
   endtask

   task automatic send(input int i, input int dest, input logic [S-1:0] sd, input logic [M-1:0] msg);
      in_msg[i*M +: M]    = msg;
      in_dest[i*NS +: NS] = NS'(dest);
      in_sd[i*S +: S]     = sd;
      in_val[i]           = 1'b1;
   endtask

   // One clock: compare DUT to model at the falling edge, advance the model at the rising edge.
   task automatic step();
      logic [N-1:0]    m_val;
      logic [N-1:0]    m_rdy;
      logic [N*16-1:0] m_stall;
      int              m_gnt [N];
      int              i;
      @(negedge clk);
      for (int p = 0; p < N; p++) m_rdy[p] = !reset && (exp_q[p].size() < D);
      for (int j = 0; j < N; j++) begin
         m_val[j] = 1'b0;
         m_gnt[j] = 0;
         for (int k = 0; k < N; k++) begin
            i = (rr[j] + k) % N;
            if (!m_val[j] && exp_q[i].size() > 0 && exp_q[i][0][E-1 -: S] == cur_sd
                && int'(exp_q[i][0][M +: NS]) == j) begin
               m_val[j] = 1'b1;
               m_gnt[j] = i;
            end
         end
      end
      m_stall = '0;
`ifdef PLAB5_MCORE_REFILL_XBAR_STATS_EN
      for (int p = 0; p < N; p++) m_stall[p*16 +: 16] = 16'(stall[p]);
`endif
      check("in_rdy", 128'(in_rdy), 128'(m_rdy));
      check("out_val", 128'(out_val), 128'(m_val));
      check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      for (int j = 0; j < N; j++) begin
         if (m_val[j] && out_val[j]) begin
            check("out_msg", 128'(out_msg[j*M +: M]), 128'(exp_q[m_gnt[j]][0][M-1:0]));
            check("out_src", 128'(out_src[j*NS +: NS]), 128'(m_gnt[j]));
         end
      end
      @(posedge clk);
      if (reset) begin
         for (int p = 0; p < N; p++) begin
            exp_q[p].delete();
            rr[p]    = 0;
            stall[p] = 0;
         end
      end else begin
         for (int p = 0; p < N; p++)
            if (exp_q[p].size() > 0 && exp_q[p][0][E-1 -: S] != cur_sd && stall[p] < 65535)
               stall[p]++;
         for (int j = 0; j < N; j++) begin
            if (m_val[j] && out_rdy[j]) begin
               if (j == 0) deliv_q.push_back(m_gnt[j]);
               void'(exp_q[m_gnt[j]].pop_front());
               rr[j] = (m_gnt[j] + 1) % N;
            end
         end
         for (int p = 0; p < N; p++)
            if (in_val[p] && m_rdy[p])
               exp_q[p].push_back({in_sd[p*S +: S], in_dest[p*NS +: NS], in_msg[p*M +: M]});
      end
      #1;
   endtask

   typedef struct {
      int           src;
      int           dest;
      logic [S-1:0] sd;
      logic [S-1:0] cur;
      logic         exp_val;
   } vec_t;

   vec_t tbl [8];
   int   exp_ord [6];
   logic accepted;

   initial begin
      tbl[0] = '{src: 0, dest: 3, sd: 1'b0, cur: 1'b0, exp_val: 1'b1};
      tbl[1] = '{src: 1, dest: 0, sd: 1'b1, cur: 1'b0, exp_val: 1'b0};
      tbl[2] = '{src: 2, dest: 1, sd: 1'b0, cur: 1'b1, exp_val: 1'b0};
      tbl[3] = '{src: 3, dest: 2, sd: 1'b1, cur: 1'b1, exp_val: 1'b1};
      tbl[4] = '{src: 3, dest: 3, sd: 1'b0, cur: 1'b0, exp_val: 1'b1};
      tbl[5] = '{src: 2, dest: 0, sd: 1'b1, cur: 1'b1, exp_val: 1'b1};
      tbl[6] = '{src: 1, dest: 2, sd: 1'b0, cur: 1'b0, exp_val: 1'b1};
      tbl[7] = '{src: 0, dest: 1, sd: 1'b1, cur: 1'b0, exp_val: 1'b0};
      exp_ord = '{0, 1, 3, 0, 1, 3};
      for (int p = 0; p < N; p++) begin
         rr[p]    = 0;
         stall[p] = 0;
      end

      // Reset
      reset   = 1'b1;
      cur_sd  = '0;
      out_rdy = '1;
      clear_inputs();
      @(posedge clk);
      #1;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rdy_after_reset", 128'(in_rdy), 128'(4'hF));

      // Single message reaches its output exactly one cycle after acceptance
      send(1, 2, 1'b0, 77'hA5);
      step();
      clear_inputs();
      check("lat_val", 128'(out_val), 128'(4'b0100));
      check("lat_msg", 128'(out_msg[2*M +: M]), 128'(77'hA5));
      check("lat_src", 128'(out_src[2*NS +: NS]), 128'(1));
      step();

      // Round-robin among inputs 0,1,3 all targeting output 0
      out_rdy = '0;
      for (int c = 0; c < 2; c++) begin
         send(0, 0, 1'b0, M'(c * 16 + 0));
         send(1, 0, 1'b0, M'(c * 16 + 1));
         send(3, 0, 1'b0, M'(c * 16 + 3));
         step();
      end
      clear_inputs();
      deliv_q.delete();
      out_rdy = '1;
      repeat (6) step();
      check("rr_count", 128'(deliv_q.size()), 128'(6));
      for (int k = 0; k < 6 && k < deliv_q.size(); k++)
         check("rr_order", 128'(deliv_q[k]), 128'(exp_ord[k]));

      // Domain gating: sd 1 message waits for 10 cycles under cur_sd 0
      send(2, 1, 1'b1, 77'h5D);
      step();
      clear_inputs();
      for (int c = 0; c < 10; c++) begin
         check("gate_val", 128'(out_val), 128'(0));
         step();
      end
`ifdef PLAB5_MCORE_REFILL_XBAR_STATS_EN
      check("gate_stall", 128'(stall_cnt[2*16 +: 16]), 128'(10));
`else
      check("gate_stall", 128'(stall_cnt), 128'(0));
`endif
      cur_sd = 1'b1;
      #1;
      check("gate_switch", 128'(out_val), 128'(4'b0010));
      step();
      cur_sd = 1'b0;

      // Backpressure: six messages into a four-deep FIFO
      out_rdy = 4'b1110;
      for (int k = 1; k <= 4; k++) begin
         send(0, 0, 1'b0, M'(k));
         step();
      end
      check("full_rdy", 128'(in_rdy[0]), 128'(0));
      out_rdy = '1;
      for (int k = 5; k <= 6; k++) begin
         send(0, 0, 1'b0, M'(k));
         accepted = 1'b0;
         for (int t = 0; t < 10 && !accepted; t++) begin
            accepted = in_rdy[0];
            step();
         end
         check("bp_accept", 128'(accepted), 128'(1));
      end
      clear_inputs();
      repeat (6) step();

      // Isolation: a FIFO full of sd 1 messages does not hold back input 1
      for (int k = 0; k < 4; k++) begin
         send(0, 0, 1'b1, M'(100 + k));
         step();
      end
      clear_inputs();
      check("iso_full", 128'(in_rdy[0]), 128'(0));
      check("iso_rdy1", 128'(in_rdy[1]), 128'(1));
      send(1, 0, 1'b0, 77'h77);
      step();
      clear_inputs();
      check("iso_val", 128'(out_val[0]), 128'(1));
      check("iso_src", 128'(out_src[0 +: NS]), 128'(1));
      step();
      cur_sd = 1'b1;
      repeat (5) step();
      cur_sd = 1'b0;

      // Reset with three messages queued
      out_rdy = '0;
      send(0, 3, 1'b0, 77'h10);
      send(1, 3, 1'b0, 77'h11);
      send(2, 3, 1'b0, 77'h12);
      step();
      clear_inputs();
      reset = 1'b1;
      step();
      check("rst_val", 128'(out_val), 128'(0));
      check("rst_rdy", 128'(in_rdy), 128'(0));
      reset = 1'b0;
      #1;
      check("rst_rdy_after", 128'(in_rdy), 128'(4'hF));
      out_rdy = '1;
      send(2, 3, 1'b0, 77'h22);
      step();
      clear_inputs();
      check("rst_new_val", 128'(out_val), 128'(4'b1000));
      check("rst_new_src", 128'(out_src[3*NS +: NS]), 128'(2));
      step();

      // Table-driven single messages under matching and mismatching domains
      for (int r = 0; r < 8; r++) begin
         cur_sd  = tbl[r].cur;
         out_rdy = '1;
         send(tbl[r].src, tbl[r].dest, tbl[r].sd, {13'h0, $urandom, $urandom});
         step();
         clear_inputs();
         check("tbl_val", 128'(out_val[tbl[r].dest]), 128'(tbl[r].exp_val));
         if (tbl[r].exp_val)
            check("tbl_src", 128'(out_src[tbl[r].dest*NS +: NS]), 128'(tbl[r].src));
         cur_sd = tbl[r].sd;
         repeat (2) step();
      end
      cur_sd = 1'b0;

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         clear_inputs();
         for (int p = 0; p < N; p++)
            if ($urandom_range(0, 2) != 0)
               send(p, $urandom_range(0, N - 1), S'($urandom_range(0, 1)), {13'h0, $urandom, $urandom});
         out_rdy = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) cur_sd = ~cur_sd;
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;
      clear_inputs();
      out_rdy = '1;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
